// File: rtl/mux_nx1_reg_pkg.sv
// Shared constants for the registered N:1 stream mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int STATS_W = 16;

  // Modulo-n increment, used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo CHANNELS.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] gnt_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                vld_o
);

  // Scan offsets 0..CHANNELS-1 from ptr; the first hit wins.
  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      c = (int'(ptr_i) + k) % CHANNELS;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 stream mux with valid/ready per channel.
// Fixed-select or round-robin grant; one output beat register.
// Optional transfer counter port xfer_cnt, enabled by MUX_NX1_REG_STATS_EN.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_NX1_REG_STATS_EN
  ,
  output logic [STATS_W-1:0]        xfer_cnt
`endif
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]    ptr_q,       ptr_d;

  logic [CHANNELS-1:0] rr_gnt, fx_gnt, gnt;
  logic [SEL_W-1:0]    rr_idx, gnt_idx;
  logic                rr_vld;
  logic                load_ok, accept;
  logic [WIDTH-1:0]    gnt_data;

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

  // Fixed-mode grant: decode sel; out-of-range sel decodes to nothing.
  always_comb begin
    fx_gnt = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel == SEL_W'(i)) fx_gnt[i] = 1'b1;
  end

  // Grant mux; mode/sel act on this cycle's grant directly.
  always_comb begin
    gnt     = fx_gnt;
    gnt_idx = sel;
    if (mode == MODE_RR) begin
      gnt     = rr_vld ? rr_gnt : '0;
      gnt_idx = rr_idx;
    end
  end

  assign load_ok  = ~out_valid_q | out_ready;
  assign in_ready = {CHANNELS{load_ok}} & gnt;
  assign accept   = |(in_valid & in_ready);

  // Data of the granted channel (gnt is one-hot or zero).
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  // Next state: accept overrides drain, so back-to-back beats leave no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      if (mode == MODE_RR)
        ptr_d = SEL_W'(wrap_inc(32'(gnt_idx), CHANNELS));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output beat register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_NX1_REG_STATS_EN
  logic [STATS_W-1:0] xfer_q;

  // Count output drains; wraps naturally at 2^STATS_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       xfer_q <= '0;
    else if (out_valid_q && out_ready) xfer_q <= xfer_q + 1'b1;
  end

  assign xfer_cnt = xfer_q;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: directed cases plus random traffic
// against a transaction-level model; a second 3-channel instance covers
// out-of-range select and asynchronous reset.
module tb_mux_nx1_reg;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel DUT
  logic              rst_n;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_valid, in_ready;
  logic [SW-1:0]     sel;
  logic              mode;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid, out_ready;
`ifdef MUX_NX1_REG_STATS_EN
  logic [15:0]       xfer_cnt;
`endif

  // 3-channel DUT
  logic              rst3_n;
  logic [3*W-1:0]    in_data3;
  logic [2:0]        in_valid3, in_ready3;
  logic [SW-1:0]     sel3;
  logic              mode3;
  logic [W-1:0]      out_data3;
  logic [SW-1:0]     out_ch3;
  logic              out_valid3, out_ready3;
`ifdef MUX_NX1_REG_STATS_EN
  logic [15:0]       xfer_cnt3;
`endif

  mux_nx1_reg #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_NX1_REG_STATS_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  mux_nx1_reg #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_NX1_REG_STATS_EN
    , .xfer_cnt(xfer_cnt3)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_vld;
  logic [W-1:0] m_data;
  int          m_ch, m_ptr;
  int unsigned m_xfer, m_drains;
  bit          last_acc;
  int          last_g;
  logic [CH-1:0] obs_rdy;

  function automatic int model_grant(input bit md, input int s, input logic [CH-1:0] v, input int p);
    if (!md) return (s < CH) ? s : -1;
    for (int k = 0; k < CH; k++)
      if (v[(p + k) % CH]) return (p + k) % CH;
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step();
    int g;
    bit load_ok, acc, drain;
    logic [CH-1:0] exp_rdy;
    logic [W-1:0] d;
    #1;
    load_ok = !m_vld || out_ready;
    g = model_grant(mode, int'(sel), in_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0 && load_ok) exp_rdy[g] = 1'b1;
    obs_rdy = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    acc   = (g >= 0) && load_ok && in_valid[g];
    drain = m_vld && out_ready;
    d     = (g >= 0) ? in_data[g*W +: W] : '0;
    @(posedge clk); #1;
    if (drain) begin
      m_xfer = (m_xfer + 1) % 65536;
      m_drains++;
    end
    if (acc) begin
      m_vld = 1; m_data = d; m_ch = g;
      if (mode) m_ptr = (g + 1) % CH;
    end else if (drain) begin
      m_vld = 0;
    end
    last_acc = acc;
    last_g   = g;
    chk("out_valid", out_valid, m_vld);
    chk("out_data", out_data, m_data);
    chk("out_ch", out_ch, m_ch);
`ifdef MUX_NX1_REG_STATS_EN
    chk("xfer_cnt", xfer_cnt, m_xfer);
`endif
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = '0; out_ready = 0; mode = 0; sel = '0; in_data = '0;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    @(negedge clk);
    rst_n = 1;
    m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_xfer = 0; m_drains = 0;
    last_acc = 0; last_g = -1;
  endtask

  initial begin
    logic [CH-1:0] v;
    rst3_n = 0; in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 0; out_ready3 = 0;
    do_reset();

    // Fixed select of channel 2
    mode = 0; sel = 2; in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5; out_ready = 1;
    step();
    chk("t1_rdy", obs_rdy, 4'b0100);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_ch", out_ch, 2);

    // Backpressure then simultaneous drain+accept
    sel = 0; in_valid = 4'b0001; in_data[0 +: W] = 8'h11;
    step();
    sel = 1; in_valid = 4'b0010; in_data[W +: W] = 8'h22; out_ready = 0;
    step();
    chk("bp_rdy", obs_rdy, 4'b0000);
    chk("bp_hold", out_data, 8'h11);
    out_ready = 1;
    step();
    chk("bp_rdy2", obs_rdy, 4'b0010);
    chk("bp_data", out_data, 8'h22);
    chk("bp_valid", out_valid, 1);

    // Round-robin, all valid: 0,1,2,3,0 with no bubble
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = W'(8'h30 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq", out_ch, k % CH);
      chk("rr_nobubble", out_valid, 1);
    end

    // Move ptr to 2 via ch1, then ch3/ch1 alternate starting at 3
    in_valid = 4'b0010;
    step();
    chk("rr_ptr_prep", out_ch, 1);
    in_valid = 4'b1010;
    step(); chk("rr31_a", out_ch, 3);
    step(); chk("rr31_b", out_ch, 1);
    step(); chk("rr31_c", out_ch, 3);

    // Random traffic obeying the hold-until-accepted producer rule
    for (int n = 0; n < 3000; n++) begin
      v = in_valid;
      for (int c = 0; c < CH; c++)
        if (!v[c] || (last_acc && last_g == c)) begin
          v[c] = 1'($urandom_range(1));
          in_data[c*W +: W] = W'($urandom);
        end
      in_valid  = v;
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) mode = ~mode;
      sel = SW'($urandom);
      step();
    end

    // 3-channel instance: out-of-range select, then async reset mid-beat
    @(negedge clk); rst3_n = 1;
    mode3 = 0; sel3 = 1; in_valid3 = 3'b010; in_data3[W +: W] = 8'h5C; out_ready3 = 1;
    @(posedge clk); #1;
    chk("c3_valid", out_valid3, 1);
    chk("c3_data", out_data3, 8'h5C);
    chk("c3_ch", out_ch3, 1);
    sel3 = 3; in_valid3 = 3'b111;
    #1 chk("c3_oor_rdy", in_ready3, 3'b000);
    @(posedge clk); #1;
    chk("c3_oor_drain", out_valid3, 0);
    chk("c3_oor_hold", out_data3, 8'h5C);
    sel3 = 2; in_valid3 = 3'b100; in_data3[2*W +: W] = 8'h7E; out_ready3 = 0;
    @(posedge clk); #1;
    chk("c3_load", out_data3, 8'h7E);
    chk("c3_load_v", out_valid3, 1);
    #2 rst3_n = 0;
    #1;
    chk("c3_async_v", out_valid3, 0);
    chk("c3_async_d", out_data3, 0);
    chk("c3_async_ch", out_ch3, 0);
    @(negedge clk); rst3_n = 1;

`ifdef MUX_NX1_REG_STATS_EN
    // Counter wrap: 70000 drains after reset
    do_reset();
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 70100 && m_drains < 70000; i++) step();
    chk("stats_drains", m_drains, 70000);
    chk("stats_wrap", xfer_cnt, 16'd4464);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
